// File: rtl/spi_cfg_sequencer_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// spi_cfg_sequencer_pkg: shared FSM encoding, defaults and helpers
// Rev 1.0
// ------------------------------------------------------------------
package spi_cfg_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_GRST = 3'd1,
    S_ADDR = 3'd2,
    S_DATA = 3'd3,
    S_GAP  = 3'd4,
    S_FIN  = 3'd5
  } state_t;

  localparam int DEF_N_SLAVES       = 3;
  localparam int DEF_ADDR_W         = 5;
  localparam int DEF_DATA_W         = 30;
  localparam int DEF_GRST_CYCLES    = 40;
  localparam int DEF_GAP_CYCLES     = 4;
  localparam int DEF_DATA_LSB_FIRST = 1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_cfg_shifter.sv
`default_nettype none
// ------------------------------------------------------------------
// spi_cfg_shifter: parallel-load serialiser, selectable bit order
// Rev 1.0
// ------------------------------------------------------------------
module spi_cfg_shifter
  import spi_cfg_sequencer_pkg::*;
#(
  parameter int W     = DEF_DATA_W,
  parameter int CNT_W = clog2(W + 1)
)(
  input  logic             clk_REGSEL,
  input  logic             RST,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [W-1:0]     i_word,
  input  logic [CNT_W-1:0] i_len,
  input  logic             i_lsb_first,
  output logic             o_bit,
  output logic             o_last
);

  logic [W-1:0]     r_sreg;
  logic [CNT_W-1:0] r_left;
  logic             r_lsb;

  // Load has priority so a new word can follow the last bit without a bubble
  always_ff @(posedge clk_REGSEL or negedge RST) begin
    if (!RST) begin
      r_sreg <= '0;
      r_left <= '0;
      r_lsb  <= 1'b0;
    end else if (i_load) begin
      r_sreg <= i_word;
      r_left <= i_len;
      r_lsb  <= i_lsb_first;
    end else if (i_shift) begin
      r_sreg <= r_lsb ? (r_sreg >> 1) : (r_sreg << 1);
      if (r_left != '0) r_left <= r_left - 1'b1;
    end
  end

  assign o_bit  = r_lsb ? r_sreg[0] : r_sreg[W-1];
  assign o_last = (r_left == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/spi_cfg_sequencer.sv
`default_nettype none
// ------------------------------------------------------------------
// spi_cfg_sequencer: table-driven GRST/REGSEL/SIN configuration sequencer
// Rev 1.0
// ------------------------------------------------------------------
module spi_cfg_sequencer
  import spi_cfg_sequencer_pkg::*;
#(
  parameter int N_SLAVES       = DEF_N_SLAVES,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int GRST_CYCLES    = DEF_GRST_CYCLES,
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int DATA_LSB_FIRST = DEF_DATA_LSB_FIRST,
  localparam int IDX_W         = max2(1, clog2(N_SLAVES))
)(
  input  logic              clk_REGSEL,
  input  logic              RST,
  input  logic              i_start,
  input  logic              i_loop,
  input  logic              i_wr_en,
  input  logic [IDX_W-1:0]  i_wr_idx,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_GRST,
  output logic              o_REGSEL,
  output logic              o_SIN,
  output logic              o_sclk_en
);

  localparam int SH_W  = max2(ADDR_W, DATA_W);
  localparam int CNT_W = clog2(max2(SH_W, max2(GRST_CYCLES, GAP_CYCLES)) + 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_idx;
  logic               r_grst, r_regsel, r_sin, r_sclk_en, r_busy, r_done;

  logic [N_SLAVES-1:0] r_valid;
  logic [ADDR_W-1:0]   r_addr [N_SLAVES];
  logic [DATA_W-1:0]   r_data [N_SLAVES];

  logic               w_wr_ok;
  logic               w_first_found, w_next_found;
  logic [IDX_W-1:0]   w_first_idx, w_next_idx, w_tgt_idx;
  logic [SH_W-1:0]    w_addr_word, w_data_word, w_sh_word;
  logic [CNT_W-1:0]   w_sh_len;
  logic               w_sh_load, w_sh_shift, w_sh_lsb, w_sh_bit, w_sh_last;

  // ---------------- configuration table ----------------
  assign w_wr_ok = i_wr_en && !r_busy &&
                   ({1'b0, i_wr_idx} < (IDX_W + 1)'(N_SLAVES));

  always_ff @(posedge clk_REGSEL or negedge RST) begin
    if (!RST) begin
      r_valid <= '0;
      for (int i = 0; i < N_SLAVES; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_valid[i_wr_idx] <= 1'b1;
      r_addr[i_wr_idx]  <= i_wr_addr;
      r_data[i_wr_idx]  <= i_wr_data;
    end
  end

  // Lowest valid index overall, and lowest valid index above the current one
  always_comb begin
    w_first_found = 1'b0;
    w_first_idx   = '0;
    w_next_found  = 1'b0;
    w_next_idx    = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if (r_valid[i]) begin
        w_first_found = 1'b1;
        w_first_idx   = IDX_W'(i);
        if (i > int'(r_idx)) begin
          w_next_found = 1'b1;
          w_next_idx   = IDX_W'(i);
        end
      end
    end
  end

  // ---------------- shifter control ----------------
  assign w_tgt_idx   = (r_state == S_GAP) ? w_next_idx : w_first_idx;
  assign w_addr_word = SH_W'(r_addr[w_tgt_idx]) << (SH_W - ADDR_W);
  assign w_data_word = (DATA_LSB_FIRST != 0) ? SH_W'(r_data[r_idx])
                                             : (SH_W'(r_data[r_idx]) << (SH_W - DATA_W));

  // Address is loaded when leaving GRST/GAP/FIN, data when leaving ADDR
  assign w_sh_word  = (r_state == S_ADDR) ? w_data_word : w_addr_word;
  assign w_sh_len   = (r_state == S_ADDR) ? CNT_W'(DATA_W) : CNT_W'(ADDR_W);
  assign w_sh_lsb   = (r_state == S_ADDR) && (DATA_LSB_FIRST != 0);
  assign w_sh_shift = (r_state == S_ADDR) || (r_state == S_DATA);

  always_comb begin
    w_sh_load = 1'b0;
    case (r_state)
      S_GRST:  w_sh_load = (r_cnt == '0) && w_first_found;
      S_ADDR:  w_sh_load = w_sh_last;
      S_GAP:   w_sh_load = (r_cnt == '0) && w_next_found;
      S_FIN:   w_sh_load = i_loop && w_first_found;
      default: w_sh_load = 1'b0;
    endcase
  end

  spi_cfg_shifter #(
    .W     (SH_W),
    .CNT_W (CNT_W)
  ) u_shifter (
    .clk_REGSEL  (clk_REGSEL),
    .RST         (RST),
    .i_load      (w_sh_load),
    .i_shift     (w_sh_shift),
    .i_word      (w_sh_word),
    .i_len       (w_sh_len),
    .i_lsb_first (w_sh_lsb),
    .o_bit       (w_sh_bit),
    .o_last      (w_sh_last)
  );

  // ---------------- sequencer FSM ----------------
  // Pins are registered from the current state, so they trail it by one cycle
  always_ff @(posedge clk_REGSEL or negedge RST) begin
    if (!RST) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_grst    <= 1'b1;
      r_regsel  <= 1'b0;
      r_sin     <= 1'b0;
      r_sclk_en <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_grst    <= (r_state == S_GRST);
      r_regsel  <= (r_state == S_ADDR);
      r_sclk_en <= w_sh_shift;
      r_sin     <= w_sh_shift & w_sh_bit;
      r_done    <= (r_state == S_FIN);
      r_busy    <= (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state <= S_GRST;
            r_cnt   <= CNT_W'(GRST_CYCLES - 1);
          end
        end
        S_GRST: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (w_first_found) begin
            r_state <= S_ADDR;
            r_idx   <= w_first_idx;
          end else begin
            r_state <= S_FIN;
          end
        end
        S_ADDR: begin
          if (w_sh_last) r_state <= S_DATA;
        end
        S_DATA: begin
          if (w_sh_last) begin
            r_state <= S_GAP;
            r_cnt   <= CNT_W'(GAP_CYCLES - 1);
          end
        end
        S_GAP: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (w_next_found) begin
            r_state <= S_ADDR;
            r_idx   <= w_next_idx;
          end else begin
            r_state <= S_FIN;
          end
        end
        S_FIN: begin
          if (i_loop && w_first_found) begin
            r_state <= S_ADDR;
            r_idx   <= w_first_idx;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_GRST    = r_grst;
  assign o_REGSEL  = r_regsel;
  assign o_SIN     = r_sin;
  assign o_sclk_en = r_sclk_en;

endmodule
`default_nettype wire

// File: tb/tb_spi_cfg_sequencer.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_spi_cfg_sequencer: directed bench, default instance plus 8-bit MSB-first instance
// Rev 1.0
// ------------------------------------------------------------------
module tb_spi_cfg_sequencer;

  logic clk_REGSEL = 1'b0;
  logic RST;
  always #5 clk_REGSEL = ~clk_REGSEL;

  logic        start0, loop0, wr_en0;
  logic [1:0]  wr_idx0;
  logic [4:0]  wr_addr0;
  logic [29:0] wr_data0;
  logic        busy0, done0, grst0, regsel0, sin0, sclk0;

  logic        start1, loop1, wr_en1;
  logic [1:0]  wr_idx1;
  logic [4:0]  wr_addr1;
  logic [7:0]  wr_data1;
  logic        busy1, done1, grst1, regsel1, sin1, sclk1;

  logic [5:0]  w_o0, w_o1;
  assign w_o0 = {grst0, regsel0, sin0, sclk0, done0, busy0};
  assign w_o1 = {grst1, regsel1, sin1, sclk1, done1, busy1};

  spi_cfg_sequencer u_dut0 (
    .clk_REGSEL (clk_REGSEL), .RST (RST),
    .i_start (start0), .i_loop (loop0), .i_wr_en (wr_en0), .i_wr_idx (wr_idx0),
    .i_wr_addr (wr_addr0), .i_wr_data (wr_data0),
    .o_busy (busy0), .o_done (done0), .o_GRST (grst0), .o_REGSEL (regsel0),
    .o_SIN (sin0), .o_sclk_en (sclk0)
  );

  spi_cfg_sequencer #(.DATA_W (8), .DATA_LSB_FIRST (0)) u_dut1 (
    .clk_REGSEL (clk_REGSEL), .RST (RST),
    .i_start (start1), .i_loop (loop1), .i_wr_en (wr_en1), .i_wr_idx (wr_idx1),
    .i_wr_addr (wr_addr1), .i_wr_data (wr_data1),
    .o_busy (busy1), .o_done (done1), .o_GRST (grst1), .o_REGSEL (regsel1),
    .o_SIN (sin1), .o_sclk_en (sclk1)
  );

  int n_chk = 0;
  int n_bad = 0;

  logic [5:0]  rec [0:255];
  logic [5:0]  ex  [0:255];
  bit          ev  [3];
  logic [4:0]  ea  [3];
  logic [29:0] ed  [3];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Trace of packed pins {GRST,REGSEL,SIN,sclk_en,done,busy}, one entry per cycle
  task automatic capture(input bit which, input int n);
    for (int j = 0; j < n; j++) begin
      @(negedge clk_REGSEL);
      rec[j] = which ? w_o1 : w_o0;
      start0 = 1'b0;
      start1 = 1'b0;
      wr_en0 = 1'b0;
      wr_en1 = 1'b0;
    end
  endtask

  task automatic build_exp(input int grst_n, input bit lead, input int dw, input bit lsb,
                           output int fin_j);
    int j;
    for (int k = 0; k < 256; k++) ex[k] = '0;
    j = lead ? 1 : 0;
    for (int g = 0; g < grst_n; g++) begin ex[j] = 6'b100001; j++; end
    for (int i = 0; i < 3; i++) begin
      if (ev[i]) begin
        for (int b = 4; b >= 0; b--) begin ex[j] = {2'b01, ea[i][b], 3'b101}; j++; end
        for (int b = 0; b < dw; b++) begin
          ex[j] = {2'b00, (lsb ? ed[i][b] : ed[i][dw-1-b]), 3'b101};
          j++;
        end
        for (int g = 0; g < 4; g++) begin ex[j] = 6'b000001; j++; end
      end
    end
    ex[j] = 6'b000011;
    fin_j = j;
  endtask

  task automatic cmp_trace(input string nm, input int upto);
    for (int j = 0; j <= upto; j++) chk($sformatf("%s[%0d]", nm, j), rec[j], ex[j]);
  endtask

  task automatic wr0(input logic [1:0] idx, input logic [4:0] a, input logic [29:0] d);
    @(negedge clk_REGSEL);
    wr_en0 = 1'b1; wr_idx0 = idx; wr_addr0 = a; wr_data0 = d;
    @(negedge clk_REGSEL);
    wr_en0 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fin, ng, nd, ns;
    bit found;
    logic [29:0] v30;
    logic [7:0]  v8;
    logic [4:0]  a5;

    start0 = 0; loop0 = 0; wr_en0 = 0; wr_idx0 = 0; wr_addr0 = 0; wr_data0 = 0;
    start1 = 0; loop1 = 0; wr_en1 = 0; wr_idx1 = 0; wr_addr1 = 0; wr_data1 = 0;
    RST = 1'b0;

    // reset values, then quiet idle
    repeat (3) @(negedge clk_REGSEL);
    chk("rst_grst", grst0, 1'b1);
    chk("rst_regsel", regsel0, 1'b0);
    chk("rst_sin", sin0, 1'b0);
    chk("rst_sclk", sclk0, 1'b0);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_done", done0, 1'b0);
    RST = 1'b1;
    repeat (2) @(negedge clk_REGSEL);
    chk("idle0", w_o0, 6'b000000);
    chk("idle1", w_o1, 6'b000000);

    // three entries, default parameters
    wr0(0, 5'd10, 30'd35);
    wr0(1, 5'd22, 30'd2);
    wr0(2, 5'd16, 30'd100);
    wr0(3, 5'd31, 30'h3FFFFFFF);
    start0 = 1'b1;
    capture(0, 170);
    ev = '{1, 1, 1}; ea = '{5'd10, 5'd22, 5'd16}; ed = '{30'd35, 30'd2, 30'd100};
    build_exp(40, 1, 30, 1, fin);
    cmp_trace("full", 165);
    ng = 0; nd = 0;
    for (int j = 0; j < 170; j++) begin
      if (rec[j][5]) ng++;
      if (rec[j][1]) nd++;
    end
    chk("full_grst_len", ng, 40);
    chk("full_done_cnt", nd, 1);
    chk("full_done_at158", rec[158][1], 1'b1);
    chk("full_busy_after", rec[159][0], 1'b0);
    for (int b = 0; b < 5; b++) a5[4-b] = rec[41+b][3];
    chk("full_addr0", a5, 5'd10);
    for (int b = 0; b < 30; b++) v30[b] = rec[46+b][3];
    chk("full_data0_lsb", v30, 30'd35);
    for (int b = 0; b < 5; b++) a5[4-b] = rec[119+b][3];
    chk("full_addr2", a5, 5'd16);

    // only entry 1 valid after reset clears the table
    RST = 1'b0;
    @(negedge clk_REGSEL);
    RST = 1'b1;
    wr0(1, 5'd22, 30'd2);
    start0 = 1'b1;
    capture(0, 90);
    ev = '{0, 1, 0};
    build_exp(40, 1, 30, 1, fin);
    cmp_trace("one", 85);
    ns = 0;
    for (int j = 0; j < 90; j++) if (rec[j][2]) ns++;
    chk("one_sclk_cnt", ns, 35);
    chk("one_done_at80", rec[80][1], 1'b1);

    // MSB-first 8-bit instance, write and start in the same idle cycle
    wr_en1 = 1'b1; wr_idx1 = 0; wr_addr1 = 5'd3; wr_data1 = 8'hA5; start1 = 1'b1;
    capture(1, 70);
    ev = '{1, 0, 0}; ea = '{5'd3, 5'd0, 5'd0}; ed = '{30'hA5, 30'd0, 30'd0};
    build_exp(40, 1, 8, 0, fin);
    cmp_trace("msb", 62);
    for (int b = 0; b < 8; b++) v8[7-b] = rec[46+b][3];
    chk("msb_bits", v8, 8'b10100101);

    // loop restart without GRST; write during busy must be ignored
    loop0 = 1'b1; start0 = 1'b1;
    found = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk_REGSEL);
      start0 = 1'b0;
      wr_en0 = (c == 10);
      if (c == 10) begin wr_idx0 = 0; wr_addr0 = 5'd5; wr_data0 = 30'd7; end
      if (done0) begin found = 1; break; end
    end
    wr_en0 = 1'b0;
    loop0  = 1'b0;
    chk("loop_done_seen", found, 1'b1);
    capture(0, 45);
    chk("loop_regsel_next", rec[0][4], 1'b1);
    chk("loop_grst_low", rec[0][5], 1'b0);
    ev = '{0, 1, 0}; ea = '{5'd0, 5'd22, 5'd0}; ed = '{30'd0, 30'd2, 30'd0};
    build_exp(0, 0, 30, 1, fin);
    cmp_trace("loop", 43);

    // reset in the middle of the data phase
    start0 = 1'b1;
    found = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk_REGSEL);
      start0 = 1'b0;
      if (sclk0 && !regsel0) begin found = 1; break; end
    end
    chk("mid_data_seen", found, 1'b1);
    RST = 1'b0;
    #1;
    chk("mid_rst_pins", w_o0, 6'b100000);
    @(negedge clk_REGSEL);
    RST = 1'b1;
    start0 = 1'b1;
    capture(0, 50);
    ev = '{0, 0, 0};
    build_exp(40, 1, 30, 1, fin);
    cmp_trace("empty", 45);
    ns = 0;
    for (int j = 0; j < 50; j++) if (rec[j][2]) ns++;
    chk("empty_sclk_cnt", ns, 0);
    chk("empty_done_at41", rec[41][1], 1'b1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
